// File: rtl/trx_sequencer.sv
// rtl/trx_sequencer.sv - RX/TX switchover sequencer: key debounce, mute, ramp, hang, unmute
module trx_sequencer #(
  parameter int DEB_CYC     = 4,
  parameter int MUTE_DLY    = 50,
  parameter int RAMP_DIV    = 2,
  parameter int RAMP_STEP   = 8,
  parameter int HANG_CYC    = 20000,
  parameter int KEY_ACT_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cw_key,
  input  logic       ptt_req,
  input  logic       pll_ok,
  input  logic [7:0] level_tgt,
  output logic       rx_mute,
  output logic       tx_en,
  output logic [7:0] level_out,
  output logic [2:0] state,
  output logic       key_db
);

  typedef enum logic [2:0] {
    ST_RX     = 3'd0,
    ST_MUTE   = 3'd1,
    ST_RAMPUP = 3'd2,
    ST_TX     = 3'd3,
    ST_HANG   = 3'd4,
    ST_RAMPDN = 3'd5,
    ST_UNMUTE = 3'd6,
    ST_BAD    = 3'd7
  } state_t;

  localparam logic        KEY_IDLE  = (KEY_ACT_LOW != 0);
  localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYC - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(RAMP_DIV - 1);
  localparam logic [7:0]  STEP8     = 8'(RAMP_STEP);
  localparam logic [15:0] MUTE_LOAD = 16'(MUTE_DLY - 1);
  localparam logic [15:0] HANG_LOAD = 16'(HANG_CYC - 1);

  logic       key_meta;
  logic       key_sync;
  logic       key_smp;
  logic [7:0] deb_cnt;
  logic       key;

  // Synchronizer flops idle at the inactive pin level so reset never looks like a key-down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta <= KEY_IDLE;
      key_sync <= KEY_IDLE;
    end else begin
      key_meta <= cw_key;
      key_sync <= key_meta;
    end
  end

  assign key_smp = key_sync ^ KEY_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt <= 8'd0;
      key_db  <= 1'b0;
    end else if (key_smp == key_db) begin
      deb_cnt <= 8'd0;
    end else if (deb_cnt == DEB_LAST) begin
      key_db  <= key_smp;
      deb_cnt <= 8'd0;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  assign key = key_db | ptt_req;

  state_t      cur_state;
  state_t      nxt_state;
  logic [15:0] timer;
  logic [15:0] nxt_timer;
  logic [7:0]  div_cnt;
  logic [7:0]  nxt_div;
  logic [7:0]  nxt_level;
  logic        nxt_tx_en;
  logic        nxt_rx_mute;
  logic        cw_seen;
  logic        nxt_cw_seen;
  logic        div_tick;
  logic [8:0]  step_up;
  logic        active;

  assign div_tick = (div_cnt == DIV_LAST);
  assign step_up  = {1'b0, level_out} + {1'b0, STEP8};
  assign active   = (cur_state == ST_MUTE) || (cur_state == ST_RAMPUP) || (cur_state == ST_TX) ||
                    (cur_state == ST_HANG) || (cur_state == ST_RAMPDN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= ST_RX;
      timer     <= 16'd0;
      div_cnt   <= 8'd0;
      level_out <= 8'd0;
      tx_en     <= 1'b0;
      rx_mute   <= 1'b0;
      cw_seen   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      timer     <= nxt_timer;
      div_cnt   <= nxt_div;
      level_out <= nxt_level;
      tx_en     <= nxt_tx_en;
      rx_mute   <= nxt_rx_mute;
      cw_seen   <= nxt_cw_seen;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    nxt_timer   = timer;
    nxt_div     = div_tick ? 8'd0 : div_cnt + 8'd1;
    nxt_level   = level_out;
    nxt_tx_en   = tx_en;
    nxt_rx_mute = rx_mute;
    // Remembers whether the CW key took part in this transmission; decides if hang applies.
    nxt_cw_seen = active ? (cw_seen | key_db) : 1'b0;

    case (cur_state)
      ST_RX: begin
        nxt_rx_mute = 1'b0;
        nxt_tx_en   = 1'b0;
        nxt_level   = 8'd0;
        if (key && pll_ok) begin
          nxt_state   = ST_MUTE;
          nxt_rx_mute = 1'b1;
          nxt_timer   = MUTE_LOAD;
        end
      end
      ST_MUTE: begin
        if (!key) begin
          nxt_state = ST_UNMUTE;
          nxt_timer = MUTE_LOAD;
        end else if (timer == 16'd0) begin
          nxt_state = ST_RAMPUP;
          nxt_tx_en = 1'b1;
        end else begin
          nxt_timer = timer - 16'd1;
        end
      end
      ST_RAMPUP: begin
        if (!key) begin
          nxt_state = ST_RAMPDN;
        end else if (level_out >= level_tgt) begin
          // Covers a zero target and a re-key from a level above a lowered target.
          nxt_level = level_tgt;
          nxt_state = ST_TX;
        end else if (div_tick) begin
          if (step_up >= {1'b0, level_tgt}) begin
            nxt_level = level_tgt;
            nxt_state = ST_TX;
          end else begin
            nxt_level = step_up[7:0];
          end
        end
      end
      ST_TX: begin
        nxt_level = level_tgt;
        if (!key) begin
          if (cw_seen) begin
            nxt_state = ST_HANG;
            nxt_timer = HANG_LOAD;
          end else begin
            nxt_state = ST_RAMPDN;
          end
        end
      end
      ST_HANG: begin
        if (key) begin
          nxt_state = ST_TX;
        end else if (timer == 16'd0) begin
          nxt_state = ST_RAMPDN;
        end else begin
          nxt_timer = timer - 16'd1;
        end
      end
      ST_RAMPDN: begin
        if (key) begin
          nxt_state = ST_RAMPUP;
        end else if (div_tick) begin
          if (level_out <= STEP8) begin
            nxt_level = 8'd0;
            nxt_tx_en = 1'b0;
            nxt_state = ST_UNMUTE;
            nxt_timer = MUTE_LOAD;
          end else begin
            nxt_level = level_out - STEP8;
          end
        end
      end
      ST_UNMUTE: begin
        nxt_tx_en   = 1'b0;
        nxt_level   = 8'd0;
        nxt_rx_mute = 1'b1;
        if (timer == 16'd0) begin
          nxt_state   = ST_RX;
          nxt_rx_mute = 1'b0;
        end else begin
          nxt_timer = timer - 16'd1;
        end
      end
      default: begin
        nxt_state   = ST_UNMUTE;
        nxt_tx_en   = 1'b0;
        nxt_level   = 8'd0;
        nxt_rx_mute = 1'b1;
        nxt_timer   = MUTE_LOAD;
      end
    endcase

    // Loss of PLL lock drops the carrier at once but keeps the receiver muted while it settles.
    if (!pll_ok && active) begin
      nxt_state   = ST_UNMUTE;
      nxt_level   = 8'd0;
      nxt_tx_en   = 1'b0;
      nxt_rx_mute = 1'b1;
      nxt_timer   = MUTE_LOAD;
    end

    if (nxt_state != cur_state) begin
      nxt_div = 8'd0;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_trx_sequencer.sv
// tb/tb_trx_sequencer.sv - directed self-checking bench for trx_sequencer
module tb_trx_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cw_key;
  logic       ptt_req;
  logic       pll_ok;
  logic [7:0] level_tgt;
  logic       rx_mute;
  logic       tx_en;
  logic [7:0] level_out;
  logic [2:0] state;
  logic       key_db;

  int n_checks = 0;
  int n_errors = 0;
  int lvl_min;

  trx_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cw_key    (cw_key),
    .ptt_req   (ptt_req),
    .pll_ok    (pll_ok),
    .level_tgt (level_tgt),
    .rx_mute   (rx_mute),
    .tx_en     (tx_en),
    .level_out (level_out),
    .state     (state),
    .key_db    (key_db)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int tgt, input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      if (int'(state) == tgt) break;
      @(negedge clk);
    end
    check(tag, int'(state), tgt);
  endtask

  always @(negedge clk) begin
    if (reset) check("mute_tx_excl", int'(rx_mute == 1'b0 && tx_en == 1'b1), 0);
  end

  initial begin
    reset     = 1'b0;
    cw_key    = 1'b1;
    ptt_req   = 1'b0;
    pll_ok    = 1'b1;
    level_tgt = 8'd100;
    cyc(3);
    check("rst_rx_mute", rx_mute, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_level", level_out, 0);
    check("rst_state", state, 0);
    check("rst_key_db", key_db, 0);
    reset = 1'b1;
    cyc(2);

    cw_key = 1'b0;
    cyc(2);
    cw_key = 1'b1;
    cyc(10);
    check("glitch_key_db", key_db, 0);
    check("glitch_state", state, 0);

    cw_key = 1'b0;
    cyc(5);
    check("deb_early", key_db, 0);
    cyc(1);
    check("deb_key_db", key_db, 1);
    check("deb_state_rx", state, 0);
    cyc(1);
    check("mute_state", state, 1);
    check("mute_rx_mute", rx_mute, 1);
    check("mute_tx_en", tx_en, 0);
    cyc(49);
    check("mute_end_state", state, 1);
    check("mute_end_tx", tx_en, 0);
    cyc(1);
    check("rampup_state", state, 2);
    check("rampup_tx", tx_en, 1);
    check("rampup_lvl0", level_out, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(2);
      check("rampup_lvl", level_out, 8 * k);
    end
    cyc(2);
    check("rampup_final", level_out, 100);
    check("tx_state", state, 3);

    cw_key = 1'b1;
    cyc(6);
    check("rel_still_tx", state, 3);
    cyc(1);
    check("hang_state", state, 4);
    check("hang_lvl", level_out, 100);
    cyc(19999);
    check("hang_end_state", state, 4);
    check("hang_end_lvl", level_out, 100);
    check("hang_end_tx", tx_en, 1);
    cyc(1);
    check("rampdn_state", state, 5);
    check("rampdn_lvl0", level_out, 100);
    for (int k = 1; k <= 12; k++) begin
      cyc(2);
      check("rampdn_lvl", level_out, 100 - 8 * k);
      check("rampdn_tx", tx_en, 1);
    end
    cyc(2);
    check("rampdn_zero", level_out, 0);
    check("rampdn_tx_off", tx_en, 0);
    check("unmute_state", state, 6);
    check("unmute_rx_mute", rx_mute, 1);
    cyc(49);
    check("unmute_hold", rx_mute, 1);
    cyc(1);
    check("unmute_release", rx_mute, 0);
    check("rx_again", state, 0);

    cw_key = 1'b0;
    wait_state(3, 300, "rekey_tx");
    cw_key = 1'b1;
    wait_state(4, 30, "rekey_hang");
    lvl_min = 255;
    for (int i = 0; i < 10000; i++) begin
      if (int'(level_out) < lvl_min) lvl_min = int'(level_out);
      cyc(1);
    end
    check("rekey_pre_state", state, 4);
    cw_key = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (int'(level_out) < lvl_min) lvl_min = int'(level_out);
    end
    check("rekey_still_hang", state, 4);
    cyc(1);
    check("rekey_back_tx", state, 3);
    check("rekey_no_dip", lvl_min, 100);

    pll_ok = 1'b0;
    cyc(1);
    check("abort_tx_state", state, 6);
    check("abort_tx_lvl", level_out, 0);
    check("abort_tx_tx", tx_en, 0);
    check("abort_tx_mute", rx_mute, 1);
    pll_ok = 1'b1;
    cw_key = 1'b1;
    cyc(49);
    check("abort_tx_unmute", state, 6);
    cyc(1);
    check("abort_tx_rx", state, 0);
    check("abort_tx_rxm", rx_mute, 0);
    check("abort_tx_keydb", key_db, 0);

    level_tgt = 8'd20;
    ptt_req   = 1'b1;
    cyc(1);
    check("ptt_mute", state, 1);
    cyc(50);
    check("ptt_rampup", state, 2);
    check("ptt_tx_en", tx_en, 1);
    cyc(2);
    check("ptt_lvl8", level_out, 8);
    cyc(2);
    check("ptt_lvl16", level_out, 16);
    cyc(2);
    check("ptt_lvl20", level_out, 20);
    check("ptt_tx", state, 3);
    ptt_req = 1'b0;
    cyc(1);
    check("ptt_nohang", state, 5);
    check("ptt_dn_lvl20", level_out, 20);
    cyc(2);
    check("ptt_dn_lvl12", level_out, 12);
    cyc(2);
    check("ptt_dn_lvl4", level_out, 4);
    cyc(2);
    check("ptt_dn_lvl0", level_out, 0);
    check("ptt_unmute", state, 6);
    check("ptt_tx_off", tx_en, 0);
    cyc(50);
    check("ptt_rx", state, 0);
    check("ptt_rxm", rx_mute, 0);

    level_tgt = 8'd100;
    ptt_req   = 1'b1;
    cyc(51);
    check("ab_rampup", state, 2);
    for (int k = 1; k <= 5; k++) begin
      cyc(2);
      check("ab_lvl", level_out, 8 * k);
    end
    pll_ok = 1'b0;
    cyc(1);
    check("ab_state", state, 6);
    check("ab_lvl0", level_out, 0);
    check("ab_tx", tx_en, 0);
    check("ab_mute", rx_mute, 1);
    cyc(49);
    check("ab_unmute_hold", state, 6);
    cyc(1);
    check("ab_rx", state, 0);
    cyc(5);
    check("ab_blocked", state, 0);
    check("ab_blocked_rxm", rx_mute, 0);
    ptt_req = 1'b0;
    pll_ok  = 1'b1;
    cyc(2);

    ptt_req = 1'b1;
    wait_state(3, 300, "tgt_tx");
    level_tgt = 8'd30;
    cyc(1);
    check("tgt_follow", level_out, 30);
    check("tgt_state", state, 3);
    ptt_req = 1'b0;
    wait_state(0, 300, "tgt_back_rx");

    level_tgt = 8'd100;
    ptt_req   = 1'b1;
    cyc(1);
    check("z_mute", state, 1);
    level_tgt = 8'd0;
    cyc(50);
    check("z_rampup", state, 2);
    check("z_lvl_up", level_out, 0);
    cyc(1);
    check("z_tx", state, 3);
    check("z_lvl_tx", level_out, 0);
    check("z_tx_en", tx_en, 1);
    ptt_req = 1'b0;
    cyc(1);
    check("z_rampdn", state, 5);
    cyc(2);
    check("z_unmute", state, 6);
    check("z_tx_off", tx_en, 0);
    wait_state(0, 100, "z_rx");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
